// File: rtl/load_store_unit.sv
// Per-thread load/store unit: issues one data-memory read (LDR) or write (STR) per instruction
// over a valid/ready handshake and exposes the last loaded value to the register file.
module load_store_unit #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs_data,
    input  logic [DATA_BITS-1:0] rt_data,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } lsu_state_t;

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    lsu_state_t           state_q, state_d;
    logic                 is_read_q, is_read_d;
    logic                 read_valid_q, read_valid_d;
    logic [ADDR_BITS-1:0] read_addr_q, read_addr_d;
    logic                 write_valid_q, write_valid_d;
    logic [ADDR_BITS-1:0] write_addr_q, write_addr_d;
    logic [DATA_BITS-1:0] write_data_q, write_data_d;
    logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;

    always_comb begin
        state_d       = state_q;
        is_read_d     = is_read_q;
        read_valid_d  = read_valid_q;
        read_addr_d   = read_addr_q;
        write_valid_d = write_valid_q;
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        lsu_out_d     = lsu_out_q;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    // Read wins when both enables are set; the write is simply dropped.
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        is_read_d = decoded_mem_read_enable;
                        state_d   = REQUESTING;
                    end
                end
                REQUESTING: begin
                    if (is_read_q) begin
                        read_valid_d = 1'b1;
                        read_addr_d  = rs_data[ADDR_BITS-1:0];
                    end else begin
                        write_valid_d = 1'b1;
                        write_addr_d  = rs_data[ADDR_BITS-1:0];
                        write_data_d  = rt_data;
                    end
                    state_d = WAITING;
                end
                WAITING: begin
                    if (is_read_q) begin
                        if (mem_read_ready) begin
                            read_valid_d = 1'b0;
                            lsu_out_d    = mem_read_data;
                            state_d      = DONE;
                        end
                    end else if (mem_write_ready) begin
                        write_valid_d = 1'b0;
                        state_d       = DONE;
                    end
                end
                DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            is_read_q     <= 1'b0;
            read_valid_q  <= 1'b0;
            read_addr_q   <= '0;
            write_valid_q <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            lsu_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            read_valid_q  <= read_valid_d;
            read_addr_q   <= read_addr_d;
            write_valid_q <= write_valid_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            lsu_out_q     <= lsu_out_d;
        end
    end

    assign mem_read_valid    = read_valid_q;
    assign mem_read_address  = read_addr_q;
    assign mem_write_valid   = write_valid_q;
    assign mem_write_address = write_addr_q;
    assign mem_write_data    = write_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = lsu_out_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit: each vector drives inputs for one clock
// edge and checks every output one time unit after that edge.
module tb_load_store_unit;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] cs;
        logic       rd;
        logic       wr;
        logic [7:0] rs;
        logic [7:0] rt;
        logic       rrdy;
        logic [7:0] rdat;
        logic       wrdy;
    } stim_t;

    typedef struct {
        logic [1:0] st;
        logic       rv;
        logic [7:0] ra;
        logic       wv;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [7:0] lo;
    } expect_t;

    typedef struct {
        stim_t   s;
        expect_t e;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       decoded_mem_read_enable;
    logic       decoded_mem_write_enable;
    logic [7:0] rs_data;
    logic [7:0] rt_data;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready;
    logic [7:0] mem_read_data;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;

    int passCount = 0;
    int totalCount = 0;

    always #5 clock = ~clock;

    load_store_unit #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .rs_data                  (rs_data),
        .rt_data                  (rt_data),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out)
    );

    function automatic stim_t mkStim(logic r, logic en, logic [2:0] cs, logic rd, logic wr,
                                     logic [7:0] rs, logic [7:0] rt, logic rrdy,
                                     logic [7:0] rdat, logic wrdy);
        stim_t s;
        s.rst_n = r;  s.en = en;  s.cs = cs;  s.rd = rd;  s.wr = wr;
        s.rs = rs;    s.rt = rt;  s.rrdy = rrdy;  s.rdat = rdat;  s.wrdy = wrdy;
        return s;
    endfunction

    function automatic expect_t mkExp(logic [1:0] st, logic rv, logic [7:0] ra, logic wv,
                                      logic [7:0] wa, logic [7:0] wd, logic [7:0] lo);
        expect_t e;
        e.st = st;  e.rv = rv;  e.ra = ra;  e.wv = wv;  e.wa = wa;  e.wd = wd;  e.lo = lo;
        return e;
    endfunction

    // Drive one set of inputs, let one rising edge happen, then settle before sampling.
    task automatic applyStimulus(input stim_t s);
        reset                    = s.rst_n;
        enable                   = s.en;
        core_state               = s.cs;
        decoded_mem_read_enable  = s.rd;
        decoded_mem_write_enable = s.wr;
        rs_data                  = s.rs;
        rt_data                  = s.rt;
        mem_read_ready           = s.rrdy;
        mem_read_data            = s.rdat;
        mem_write_ready          = s.wrdy;
        @(posedge clock);
        #1;
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        totalCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkOutput(input string tag, input expect_t e);
        cmp({tag, " lsu_state"},         {6'd0, lsu_state},       {6'd0, e.st});
        cmp({tag, " mem_read_valid"},    {7'd0, mem_read_valid},  {7'd0, e.rv});
        cmp({tag, " mem_read_address"},  mem_read_address,        e.ra);
        cmp({tag, " mem_write_valid"},   {7'd0, mem_write_valid}, {7'd0, e.wv});
        cmp({tag, " mem_write_address"}, mem_write_address,       e.wa);
        cmp({tag, " mem_write_data"},    mem_write_data,          e.wd);
        cmp({tag, " lsu_out"},           lsu_out,                 e.lo);
    endtask

    vec_t vecs[21];

    initial begin
        stim_t s;

        // reset
        vecs[0]  = '{mkStim(0,0,3'd0,0,0,8'h00,8'h00,0,8'h00,0), mkExp(2'd0,0,8'h00,0,8'h00,8'h00,8'h00)};
        // LDR 0x2A, ready three cycles after valid with data 0x5C
        vecs[1]  = '{mkStim(1,1,3'd3,1,0,8'h2A,8'h00,0,8'h00,0), mkExp(2'd1,0,8'h00,0,8'h00,8'h00,8'h00)};
        vecs[2]  = '{mkStim(1,1,3'd0,0,0,8'h2A,8'h00,0,8'h00,0), mkExp(2'd2,1,8'h2A,0,8'h00,8'h00,8'h00)};
        vecs[3]  = '{mkStim(1,1,3'd0,0,0,8'h2A,8'h00,0,8'h00,0), mkExp(2'd2,1,8'h2A,0,8'h00,8'h00,8'h00)};
        vecs[4]  = '{mkStim(1,1,3'd0,0,0,8'h2A,8'h00,0,8'h00,0), mkExp(2'd2,1,8'h2A,0,8'h00,8'h00,8'h00)};
        vecs[5]  = '{mkStim(1,1,3'd0,0,0,8'h2A,8'h00,1,8'h5C,0), mkExp(2'd3,0,8'h2A,0,8'h00,8'h00,8'h5C)};
        vecs[6]  = '{mkStim(1,1,3'd4,0,0,8'h00,8'h00,0,8'h00,0), mkExp(2'd3,0,8'h2A,0,8'h00,8'h00,8'h5C)};
        vecs[7]  = '{mkStim(1,1,3'd6,0,0,8'h00,8'h00,0,8'h00,0), mkExp(2'd0,0,8'h2A,0,8'h00,8'h00,8'h5C)};
        // STR 0xA7 -> 0x10; a read-ready pulse while waiting must be ignored
        vecs[8]  = '{mkStim(1,1,3'd3,0,1,8'h10,8'hA7,0,8'h00,0), mkExp(2'd1,0,8'h2A,0,8'h00,8'h00,8'h5C)};
        vecs[9]  = '{mkStim(1,1,3'd0,0,0,8'h10,8'hA7,0,8'h00,0), mkExp(2'd2,0,8'h2A,1,8'h10,8'hA7,8'h5C)};
        vecs[10] = '{mkStim(1,1,3'd0,0,0,8'h10,8'hA7,1,8'hFF,0), mkExp(2'd2,0,8'h2A,1,8'h10,8'hA7,8'h5C)};
        vecs[11] = '{mkStim(1,1,3'd0,0,0,8'h10,8'hA7,0,8'h00,1), mkExp(2'd3,0,8'h2A,0,8'h10,8'hA7,8'h5C)};
        vecs[12] = '{mkStim(1,1,3'd6,0,0,8'h00,8'h00,0,8'h00,0), mkExp(2'd0,0,8'h2A,0,8'h10,8'hA7,8'h5C)};
        // both enables: read only; write-ready ignored while a read is outstanding
        vecs[13] = '{mkStim(1,1,3'd3,1,1,8'h33,8'h44,0,8'h00,0), mkExp(2'd1,0,8'h2A,0,8'h10,8'hA7,8'h5C)};
        vecs[14] = '{mkStim(1,1,3'd0,0,0,8'h33,8'h44,0,8'h00,0), mkExp(2'd2,1,8'h33,0,8'h10,8'hA7,8'h5C)};
        vecs[15] = '{mkStim(1,1,3'd0,0,0,8'h33,8'h44,0,8'h00,1), mkExp(2'd2,1,8'h33,0,8'h10,8'hA7,8'h5C)};
        vecs[16] = '{mkStim(1,1,3'd0,0,0,8'h33,8'h44,1,8'h99,0), mkExp(2'd3,0,8'h33,0,8'h10,8'hA7,8'h99)};
        vecs[17] = '{mkStim(1,1,3'd6,0,0,8'h00,8'h00,0,8'h00,0), mkExp(2'd0,0,8'h33,0,8'h10,8'hA7,8'h99)};
        // ready in IDLE, REQUEST without enables, request while disabled: all stay IDLE
        vecs[18] = '{mkStim(1,1,3'd0,0,0,8'h00,8'h00,1,8'h11,1), mkExp(2'd0,0,8'h33,0,8'h10,8'hA7,8'h99)};
        vecs[19] = '{mkStim(1,1,3'd3,0,0,8'h55,8'h66,0,8'h00,0), mkExp(2'd0,0,8'h33,0,8'h10,8'hA7,8'h99)};
        vecs[20] = '{mkStim(1,0,3'd3,1,0,8'h55,8'h66,0,8'h00,0), mkExp(2'd0,0,8'h33,0,8'h10,8'hA7,8'h99)};

        applyStimulus(mkStim(0,0,3'd0,0,0,8'h00,8'h00,0,8'h00,0));

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput($sformatf("vec%0d", i), vecs[i].e);
        end

        // Read stalled by enable=0 for four cycles while ready is pulsed, then completes.
        applyStimulus(mkStim(1,1,3'd3,1,0,8'h5A,8'h00,0,8'h00,0));
        checkOutput("hold req", mkExp(2'd1,0,8'h33,0,8'h10,8'hA7,8'h99));
        applyStimulus(mkStim(1,1,3'd0,0,0,8'h5A,8'h00,0,8'h00,0));
        checkOutput("hold wait", mkExp(2'd2,1,8'h5A,0,8'h10,8'hA7,8'h99));
        for (int i = 0; i < 4; i++) begin
            s = mkStim(1,0,3'd6,1,1,8'h01,8'h02,1'(i % 2 == 0),8'hEE,1);
            applyStimulus(s);
            checkOutput($sformatf("disabled%0d", i), mkExp(2'd2,1,8'h5A,0,8'h10,8'hA7,8'h99));
        end
        applyStimulus(mkStim(1,1,3'd0,0,0,8'h00,8'h00,0,8'h00,0));
        checkOutput("reenable", mkExp(2'd2,1,8'h5A,0,8'h10,8'hA7,8'h99));
        applyStimulus(mkStim(1,1,3'd0,0,0,8'h00,8'h00,1,8'hEE,0));
        checkOutput("reenable done", mkExp(2'd3,0,8'h5A,0,8'h10,8'hA7,8'hEE));

        // DONE must hold for as long as the scheduler is not in UPDATE.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mkStim(1,1,3'd4,0,0,8'h00,8'h00,0,8'h00,0));
            checkOutput($sformatf("done hold%0d", i), mkExp(2'd3,0,8'h5A,0,8'h10,8'hA7,8'hEE));
        end
        applyStimulus(mkStim(1,1,3'd6,0,0,8'h00,8'h00,0,8'h00,0));
        checkOutput("done update", mkExp(2'd0,0,8'h5A,0,8'h10,8'hA7,8'hEE));

        // Reset with a read outstanding drops the request and clears everything.
        applyStimulus(mkStim(1,1,3'd3,1,0,8'h77,8'h00,0,8'h00,0));
        applyStimulus(mkStim(1,1,3'd0,0,0,8'h77,8'h00,0,8'h00,0));
        checkOutput("rst wait", mkExp(2'd2,1,8'h77,0,8'h10,8'hA7,8'hEE));
        applyStimulus(mkStim(0,1,3'd0,0,0,8'h77,8'h00,1,8'h42,0));
        checkOutput("rst mid", mkExp(2'd0,0,8'h00,0,8'h00,8'h00,8'h00));
        applyStimulus(mkStim(1,1,3'd3,0,0,8'h77,8'h00,0,8'h00,0));
        checkOutput("rst after", mkExp(2'd0,0,8'h00,0,8'h00,8'h00,8'h00));

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
